// File: rtl/stack_reader.sv
// Pops words off an external stack into a 2-entry output buffer and streams them to a ready/valid sink.
// Optional delivered-word counter out_count is enabled by defining STACK_READER_STATS_EN.
module stack_reader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] stk_data,
    input  logic             stk_empty,
    input  logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             flush_done
`ifdef STACK_READER_STATS_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count;
    logic             capture;
    logic             transfer;
    logic             flush_exit;
    logic             flush_done_q;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("stack_reader: CNT_W must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pops are withheld during a push because the stack ignores a coincident pop.
    always_comb begin
        state_next = state;
        stk_pop    = 1'b0;
        flush_exit = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_next = FLUSH;
                end else if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                stk_pop = !stk_empty && !stk_push && (count != 2'd2);
                if (flush) begin
                    state_next = FLUSH;
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                stk_pop = !stk_empty && !stk_push;
                if (stk_empty && !stk_push) begin
                    flush_exit = 1'b1;
                    state_next = enable ? RUN : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign capture   = stk_pop && (state == RUN);
    assign out_valid = (count != 2'd0);
    assign transfer  = out_valid && out_ready;
    assign out_data  = head_q;

    // A capture only coincides with a transfer when exactly one word is held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= 2'd0;
        end else if (flush && (state != FLUSH)) begin
            count <= 2'd0;
        end else begin
            case ({capture, transfer})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_q <= stk_data;
                    end else begin
                        tail_q <= stk_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    head_q <= stk_data;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= flush_exit;
        end
    end

    assign flush_done = flush_done_q;

`ifdef STACK_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_count <= '0;
        end else if (transfer && (out_count != {CNT_W{1'b1}})) begin
            out_count <= out_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_reader.sv
// Directed self-checking bench for stack_reader with a behavioural stack model.
// Define STACK_READER_STATS_EN to also exercise the saturating out_count.
module tb_stack_reader;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             flush;
    logic [WIDTH-1:0] stk_data;
    logic             stk_empty;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush_done;
`ifdef STACK_READER_STATS_EN
    logic [CNT_W-1:0] out_count;
`endif

    logic             push_req;
    logic [WIDTH-1:0] push_val;
    logic [WIDTH-1:0] mem [0:31];
    int               sp = 0;

    int tests_run    = 0;
    int tests_failed = 0;

    stack_reader #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .flush     (flush),
        .stk_data  (stk_data),
        .stk_empty (stk_empty),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush_done(flush_done)
`ifdef STACK_READER_STATS_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: top of stack is mem[sp-1]; it is not reset by reset_n.
    assign stk_push  = push_req;
    assign stk_empty = (sp == 0);
    assign stk_data  = (sp > 0) ? mem[5'(sp - 1)] : '0;

    always @(posedge clk) begin
        if (push_req) begin
            mem[sp[4:0]] <= push_val;
            sp <= sp + 1;
        end else if (stk_pop && (sp > 0)) begin
            sp <= sp - 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic en, input logic fl, input logic rdy);
        enable    = en;
        flush     = fl;
        out_ready = rdy;
        #1;
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] v);
        push_val = v;
        push_req = 1'b1;
        nextCycle();
        push_req = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        push_req  = 1'b0;
        push_val  = '0;
        nextCycle();
        nextCycle();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_pop", 32'(stk_pop), 32'd0);
        checkOutput("rst_fdone", 32'(flush_done), 32'd0);
`ifdef STACK_READER_STATS_EN
        checkOutput("rst_count", 32'(out_count), 32'd0);
`endif
        reset_n = 1'b1;

        // Three words, full throughput: C, B, A on consecutive cycles.
        pushWord(16'hA00A);
        pushWord(16'hB00B);
        pushWord(16'hC00C);
        checkOutput("t1_depth", 32'(sp), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t1_idle_pop", 32'(stk_pop), 32'd0);
        nextCycle();
        checkOutput("t1_run_pop", 32'(stk_pop), 32'd1);
        checkOutput("t1_valid0", 32'(out_valid), 32'd0);
        nextCycle();
        checkOutput("t1_valid_c", 32'(out_valid), 32'd1);
        checkOutput("t1_data_c", 32'(out_data), 32'hC00C);
        nextCycle();
        checkOutput("t1_data_b", 32'(out_data), 32'hB00B);
        nextCycle();
        checkOutput("t1_data_a", 32'(out_data), 32'hA00A);
        checkOutput("t1_empty", 32'(stk_empty), 32'd1);
        nextCycle();
        checkOutput("t1_valid_end", 32'(out_valid), 32'd0);
`ifdef STACK_READER_STATS_EN
        checkOutput("t1_count", 32'(out_count), 32'd3);
`endif

        // Backpressure: only two pops, head held until the sink is ready.
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        pushWord(16'hD001);
        pushWord(16'hD002);
        pushWord(16'hD003);
        pushWord(16'hD004);
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("t2_first", 32'(out_data), 32'hD004);
        checkOutput("t2_pop1", 32'(stk_pop), 32'd1);
        nextCycle();
        checkOutput("t2_depth", 32'(sp), 32'd2);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("t2_hold_data", 32'(out_data), 32'hD004);
            checkOutput("t2_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t2_hold_pop", 32'(stk_pop), 32'd0);
            checkOutput("t2_hold_depth", 32'(sp), 32'd2);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        nextCycle();
        checkOutput("t2_data_d3", 32'(out_data), 32'hD003);
        nextCycle();
        checkOutput("t2_data_d2", 32'(out_data), 32'hD002);
        nextCycle();
        checkOutput("t2_data_d1", 32'(out_data), 32'hD001);
        nextCycle();
        checkOutput("t2_valid_end", 32'(out_valid), 32'd0);
`ifdef STACK_READER_STATS_EN
        checkOutput("t2_count", 32'(out_count), 32'd7);
`endif

        // Pushes in RUN suppress pops; nothing is lost or duplicated.
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        pushWord(16'hE001);
        pushWord(16'hE002);
        pushWord(16'hE003);
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("t3_head", 32'(out_data), 32'hE003);
        push_val = 16'hE004;
        push_req = 1'b1;
        #1;
        checkOutput("t3_push1_pop", 32'(stk_pop), 32'd0);
        nextCycle();
        push_val = 16'hE005;
        #1;
        checkOutput("t3_push2_pop", 32'(stk_pop), 32'd0);
        nextCycle();
        push_req = 1'b0;
        #1;
        checkOutput("t3_depth", 32'(sp), 32'd4);
        checkOutput("t3_pop_resume", 32'(stk_pop), 32'd1);
        checkOutput("t3_head_kept", 32'(out_data), 32'hE003);
        applyStimulus(1'b1, 1'b0, 1'b1);
        nextCycle();
        checkOutput("t3_data_e5", 32'(out_data), 32'hE005);
        nextCycle();
        checkOutput("t3_data_e4", 32'(out_data), 32'hE004);
        nextCycle();
        checkOutput("t3_data_e2", 32'(out_data), 32'hE002);
        nextCycle();
        checkOutput("t3_data_e1", 32'(out_data), 32'hE001);
        nextCycle();
        checkOutput("t3_valid_end", 32'(out_valid), 32'd0);
`ifdef STACK_READER_STATS_EN
        checkOutput("t3_count", 32'(out_count), 32'd12);
`endif

        // Flush with a full buffer and two words left on the stack.
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        pushWord(16'hF001);
        pushWord(16'hF002);
        pushWord(16'hF003);
        pushWord(16'hF004);
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("t4_full_valid", 32'(out_valid), 32'd1);
        checkOutput("t4_full_depth", 32'(sp), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_req_pop", 32'(stk_pop), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4_cleared", 32'(out_valid), 32'd0);
        checkOutput("t4_fpop1", 32'(stk_pop), 32'd1);
        checkOutput("t4_fdone_a", 32'(flush_done), 32'd0);
        nextCycle();
        checkOutput("t4_fpop2", 32'(stk_pop), 32'd1);
        checkOutput("t4_depth1", 32'(sp), 32'd1);
        checkOutput("t4_still_clr", 32'(out_valid), 32'd0);
        nextCycle();
        checkOutput("t4_depth0", 32'(sp), 32'd0);
        checkOutput("t4_nopop", 32'(stk_pop), 32'd0);
        checkOutput("t4_fdone_b", 32'(flush_done), 32'd0);
        nextCycle();
        checkOutput("t4_fdone_pulse", 32'(flush_done), 32'd1);
        checkOutput("t4_valid_x", 32'(out_valid), 32'd0);
        nextCycle();
        checkOutput("t4_fdone_low", 32'(flush_done), 32'd0);
        pushWord(16'h6001);
        checkOutput("t4_back_run", 32'(stk_pop), 32'd1);
        nextCycle();
        checkOutput("t4_run_valid", 32'(out_valid), 32'd1);
        checkOutput("t4_run_data", 32'(out_data), 32'h6001);
`ifdef STACK_READER_STATS_EN
        checkOutput("t4_count", 32'(out_count), 32'd12);
`endif

        // Reset in the middle of a flush: no flush_done, outputs back to reset values.
        applyStimulus(1'b1, 1'b0, 1'b1);
        nextCycle();
        checkOutput("t5_drained", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        pushWord(16'h7001);
        pushWord(16'h7002);
        applyStimulus(1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_fpop", 32'(stk_pop), 32'd1);
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        #1;
        checkOutput("t5_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_data", 32'(out_data), 32'd0);
        checkOutput("t5_pop", 32'(stk_pop), 32'd0);
        checkOutput("t5_fdone", 32'(flush_done), 32'd0);
`ifdef STACK_READER_STATS_EN
        checkOutput("t5_count", 32'(out_count), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("t5_no_fdone", 32'(flush_done), 32'd0);
            checkOutput("t5_idle_pop", 32'(stk_pop), 32'd0);
        end
        checkOutput("t5_depth", 32'(sp), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("t5_after_valid", 32'(out_valid), 32'd1);
        checkOutput("t5_after_data", 32'(out_data), 32'h7001);
        nextCycle();
        checkOutput("t5_after_end", 32'(out_valid), 32'd0);

`ifdef STACK_READER_STATS_EN
        // Twenty more transfers drive the 4-bit counter into saturation.
        checkOutput("t6_start", 32'(out_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 20; i++) begin
            pushWord(16'h0100 + 16'(i));
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (25) nextCycle();
        checkOutput("t6_valid_end", 32'(out_valid), 32'd0);
        checkOutput("t6_saturate", 32'(out_count), 32'd15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stack_reader.md
STACK_READER -- requirements
Module: stack_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the width in bits of each stack word and of each output word.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the delivered-word counter (used only when STACK_READER_STATS_EN is defined).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: level; when high, the block may pop the stack.
REQ-006 SHALL have port flush, input, 1 bit: single-cycle request to discard the buffer and the whole stack contents.
REQ-007 SHALL have port stk_data, input, WIDTH bits: the current top-of-stack word, combinationally valid while stk_empty is low.
REQ-008 SHALL have port stk_empty, input, 1 bit: the stack is empty.
REQ-009 SHALL have port stk_push, input, 1 bit: a copy of the stack's push strobe from the upstream writer.
REQ-010 SHALL have port stk_pop, output, 1 bit: pop strobe to the stack.
REQ-011 SHALL have port out_data, output, WIDTH bits: the head word of the output stream.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-013 SHALL have port out_ready, input, 1 bit: the sink accepts the word; a transfer occurs when out_valid and out_ready are both high.
REQ-014 SHALL have port flush_done, output, 1 bit: one-cycle pulse when a flush completes.
REQ-015 SHALL have port out_count, output, CNT_W bits: the number of words delivered (present only when STACK_READER_STATS_EN is defined).

Function
REQ-016 SHALL contain a 2-entry internal FIFO buffer in LIFO pop order, with an occupancy count of 0..2.
REQ-017 SHALL implement an FSM with three states: IDLE, RUN and FLUSH.
- IDLE to RUN when enable=1.
- RUN to IDLE when enable=0.
- IDLE or RUN to FLUSH when flush=1.
- FLUSH to RUN (or to IDLE if enable=0) on the cycle after stk_empty=1 with no stk_push.
REQ-018 SHALL drive stk_pop combinationally, high only when all of these hold: state is RUN, stk_empty=0, stk_push=0, and count<2; the stack ignores a pop that coincides with a push, so a pop SHALL never be issued then.
REQ-019 SHALL capture stk_data into the buffer at the clock edge on which stk_pop is high; zero-cycle capture latency.
REQ-020 SHALL drive out_valid equal to (count!=0) and out_data from the buffer head register, with no combinational path from out_ready.
REQ-021 SHALL update count by +1 on a capture alone, -1 on a transfer alone, and leave it unchanged when both occur in the same cycle.
REQ-022 SHALL deliver full throughput of one word per cycle in steady state with out_ready held high.
REQ-023 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL handle FLUSH as follows:
- Clear the buffer (count=0, out_valid=0) on the cycle flush is sampled.
- In FLUSH, drive stk_pop=1 whenever stk_empty=0 and stk_push=0, and discard the popped data.
- On exit from FLUSH, pulse flush_done high for exactly one cycle.
REQ-025 SHALL ignore flush while already in FLUSH.
REQ-026 SHALL keep the buffer contents and allow them to drain to the sink in IDLE, with no pops issued.

Reset
REQ-027 SHALL apply the following on the clock edge where reset_n=0: state=IDLE, count=0, out_valid=0, out_data=0, stk_pop=0, flush_done=0, out_count=0.
REQ-028 SHALL, when reset occurs mid-flush or mid-transfer, abandon the operation with no flush_done pulse, and leave stack state to the stack's own reset.

Configuration
REQ-029 SHALL include out_count only when the macro STACK_READER_STATS_EN is defined:
- With the macro: out_count increments by 1 per transfer and saturates at 2^CNT_W-1; flushed words are not counted.
- Without the macro: the port and counter logic are absent, and all other behaviour is identical.

Verification
REQ-030 SHALL cover: stack holds 3 words A,B,C (C on top), enable=1, out_ready=1 -> out_valid delivers C,B,A on consecutive cycles, stk_empty rises, out_valid falls.
REQ-031 SHALL cover: out_ready=0 with 4 words stacked -> exactly 2 pops occur, stk_pop stays 0, and out_data stays constant until out_ready=1.
REQ-032 SHALL cover: stk_push=1 for 2 cycles during RUN with a non-empty stack -> stk_pop=0 in those 2 cycles and no word is lost or duplicated.
REQ-033 SHALL cover: 4 words stacked, count=2, flush pulse -> out_valid=0 the next cycle, 2 further pops (4 total), flush_done pulses once after stk_empty=1, and the state returns to RUN.
REQ-034 SHALL cover: reset_n=0 for one cycle mid-FLUSH -> all outputs take their REQ-027 values and no flush_done pulse occurs.
REQ-035 SHALL cover: with STACK_READER_STATS_EN defined, CNT_W=4 and 20 words transferred -> out_count saturates at 15.
